// File: rtl/mdu_if.sv
// mdu_if: request/response bundle between the decoder/hazard path and the
// iterative multiply/divide unit.
//   start/funct3/a/b/flush : request side (driven by the pipeline)
//   busy/stall/done/result : response side (driven by mdu_iter)
interface mdu_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, a, b, flush,
                  input  busy, stall, done, result);
  modport slave  (input  start, funct3, a, b, flush,
                  output busy, stall, done, result);
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high
//   bus    : mdu_if slave port
//     start/funct3/a/b : request, sampled only in IDLE
//     flush            : abort any operation, no done issued
//     busy             : high in CALC and DONE
//     stall            : start-in-IDLE or CALC (combinational)
//     done/result      : one-cycle pulse, result held until next DONE entry
// Multiply is shift-add, divide is restoring; both iterate 32 times over
// operand magnitudes and fix the sign when the last step lands.
module mdu_iter #(parameter int XLEN = 32) (
  input  logic clk,
  input  logic reset,
  mdu_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          r_state;
  logic [4:0]      r_cnt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_hi;      // mul: product high half / div: partial remainder
  logic [XLEN-1:0] r_lo;      // mul: multiplier shifting out / div: dividend -> quotient
  logic [XLEN-1:0] r_b;       // multiplicand or divisor magnitude
  logic            r_neg_q;   // negate product / quotient
  logic            r_neg_r;   // negate remainder (sign of a)
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  // ---------------- request decode ----------------
  logic            w_is_div, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
  logic [XLEN-1:0] w_a_mag, w_b_mag;
  logic            w_div0, w_ovf, w_special;
  logic [XLEN-1:0] w_spec_res;

  always_comb begin
    w_is_div = bus.funct3[2];
    w_a_sgn  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
               (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    w_b_sgn  = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
               (bus.funct3 == 3'b110);
    w_a_neg  = w_a_sgn & bus.a[XLEN-1];
    w_b_neg  = w_b_sgn & bus.b[XLEN-1];
    w_a_mag  = w_a_neg ? -bus.a : bus.a;
    w_b_mag  = w_b_neg ? -bus.b : bus.b;
    w_div0   = w_is_div && (bus.b == '0);
    // only DIV/REM (funct3[0]==0) are signed among the divides
    w_ovf    = w_is_div && !bus.funct3[0] && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) &&
               (bus.b == '1);
    w_special = w_div0 | w_ovf;
    // funct3[1] distinguishes REM/REMU from DIV/DIVU
    if (w_div0)
      w_spec_res = bus.funct3[1] ? bus.a : '1;
    else
      w_spec_res = bus.funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

  // ---------------- one iteration step ----------------
  logic [XLEN:0]   w_sum;     // carry + high half after conditional add
  logic [XLEN:0]   w_shift;   // remainder shifted left with next dividend bit
  logic            w_ge;
  logic [XLEN-1:0] w_sub;
  logic [XLEN-1:0] w_hi_nxt, w_lo_nxt;

  always_comb begin
    w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    w_shift = {r_hi, r_lo[XLEN-1]};
    w_ge    = (w_shift >= {1'b0, r_b});
    // difference fits XLEN bits whenever w_ge holds
    w_sub   = w_shift[XLEN-1:0] - r_b;
    if (r_op[2]) begin
      w_hi_nxt = w_ge ? w_sub : w_shift[XLEN-1:0];
      w_lo_nxt = {r_lo[XLEN-2:0], w_ge};
    end else begin
      w_hi_nxt = w_sum[XLEN:1];
      w_lo_nxt = {w_sum[0], r_lo[XLEN-1:1]};
    end
  end

  // ---------------- final result from the last step ----------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem, w_final;

  always_comb begin
    w_prod = {w_hi_nxt, w_lo_nxt};
    if (r_neg_q) w_prod = -w_prod;
    w_quo  = r_neg_q ? -w_lo_nxt : w_lo_nxt;
    w_rem  = r_neg_r ? -w_hi_nxt : w_hi_nxt;
    case (r_op)
      3'b000:         w_final = w_prod[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         w_final = w_prod[2*XLEN-1:XLEN];
      3'b100, 3'b101: w_final = w_quo;
      default:        w_final = w_rem;
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_b      <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else if (bus.flush) begin
      // abort from any state; result keeps its last value
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op    <= bus.funct3;
            r_hi    <= '0;
            r_lo    <= w_a_mag;
            r_b     <= w_b_mag;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            if (w_special) begin
              r_result <= w_spec_res;
              r_done   <= 1'b1;
              r_state  <= S_DONE;
            end else begin
              r_state  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_hi  <= w_hi_nxt;
          r_lo  <= w_lo_nxt;
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'(XLEN-1)) begin
            r_result <= w_final;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;
  assign bus.stall  = (bus.start && (r_state == S_IDLE)) || (r_state == S_CALC);

endmodule
